// File: rtl/seq_detect_frontend.sv
// rtl/seq_detect_frontend.sv - synchronised, debounced sample front-end with programmable pattern detector
//
// Purpose:
//   Brings the raw push-button and data switch into the FPGAclk domain,
//   debounces the button, and produces one-cycle sample strobes from either
//   button presses or a slow internal tick. Each sample shifts the switch
//   value into a PAT_W-bit history that is compared against PATTERN.
//
// Ports:
//   FPGAclk   in   system clock
//   startSeq  in   asynchronous active-low reset
//   clkPb     in   raw active-low sample button (asynchronous)
//   SwitchIn  in   raw serial data switch (asynchronous)
//   autoMode  in   1 = sample on slow tick, 0 = sample on button press
//   serOut    out  match flag for the current sample period
//   synchOut  out  one-cycle sample strobe
//   matchCnt  out  saturating match count
//   history   out  last PAT_W sampled bits, newest in LSB
//   LED3      out  last sampled bit
//   LED4      out  heartbeat, toggles on every slow tick

module seq_detect_frontend #(
    parameter int unsigned      DIV_COUNT    = 50_000_000,
    parameter int unsigned      DEBOUNCE_CYC = 500_000,
    parameter int unsigned      PAT_W        = 4,
    parameter logic [PAT_W-1:0] PATTERN      = 4'b1011,
    parameter bit               OVERLAP      = 1'b1,
    parameter int unsigned      CNT_W        = 8
) (
    input  logic             FPGAclk,
    input  logic             startSeq,
    input  logic             clkPb,
    input  logic             SwitchIn,
    input  logic             autoMode,
    output logic             serOut,
    output logic             synchOut,
    output logic [CNT_W-1:0] matchCnt,
    output logic [PAT_W-1:0] history,
    output logic             LED3,
    output logic             LED4
);

    localparam int unsigned DIV_W  = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam int unsigned DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_COUNT - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    // Synchronisers
    logic pb_meta_q, pb_meta_d;
    logic pb_sync_q, pb_sync_d;
    logic sw_meta_q, sw_meta_d;
    logic sw_sync_q, sw_sync_d;

    // Debounce
    logic             db_level_q, db_level_d;
    logic             db_prev_q,  db_prev_d;
    logic [DEB_W-1:0] db_cnt_q,   db_cnt_d;
    logic             press_evt;

    // Divider / heartbeat
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             led4_q,    led4_d;
    logic             tick;

    // Sampling and detection
    logic              strobe_q,  strobe_d;
    logic              eval_q,    eval_d;
    logic [PAT_W-1:0]  history_q, history_d;
    logic              led3_q,    led3_d;
    logic [FILL_W-1:0] fill_q,    fill_d;
    logic              ser_q,     ser_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              match;

    always_comb begin
        pb_meta_d  = clkPb;
        pb_sync_d  = pb_meta_q;
        sw_meta_d  = SwitchIn;
        sw_sync_d  = sw_meta_q;

        // The counter only runs while the synced button disagrees with the
        // accepted level; any agreement restarts the stability window.
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (pb_sync_q != db_level_q) begin
            if (db_cnt_q == DEB_LAST) begin
                db_level_d = ~db_level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        db_prev_d  = db_level_q;
        // Falling edge of the accepted level is a press; release is silent.
        press_evt  = db_prev_q & ~db_level_q;

        tick       = (div_cnt_q == DIV_LAST);
        div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
        led4_d     = led4_q ^ tick;

        strobe_d   = autoMode ? tick : press_evt;
        eval_d     = strobe_q;

        // Match is judged one cycle after the strobe, once history and fill
        // already hold the new sample.
        match      = (fill_q == FILL_FULL) && (history_q == PATTERN);

        history_d  = history_q;
        led3_d     = led3_q;
        fill_d     = fill_q;
        if (strobe_q) begin
            history_d = {history_q[PAT_W-2:0], sw_sync_q};
            led3_d    = sw_sync_q;
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end else if (eval_q && match && !OVERLAP) begin
            // History is kept, but a fresh PAT_W samples are needed to match again.
            fill_d = '0;
        end

        ser_d = eval_q ? match : ser_q;

        cnt_d = cnt_q;
        if (eval_q && match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge FPGAclk or negedge startSeq) begin
        if (!startSeq) begin
            // Synchronisers idle high, matching the released active-low button.
            pb_meta_q  <= 1'b1;
            pb_sync_q  <= 1'b1;
            sw_meta_q  <= 1'b1;
            sw_sync_q  <= 1'b1;
            db_level_q <= 1'b1;
            db_prev_q  <= 1'b1;
            db_cnt_q   <= '0;
            div_cnt_q  <= '0;
            led4_q     <= 1'b0;
            strobe_q   <= 1'b0;
            eval_q     <= 1'b0;
            history_q  <= '0;
            led3_q     <= 1'b0;
            fill_q     <= '0;
            ser_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pb_meta_q  <= pb_meta_d;
            pb_sync_q  <= pb_sync_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            db_level_q <= db_level_d;
            db_prev_q  <= db_prev_d;
            db_cnt_q   <= db_cnt_d;
            div_cnt_q  <= div_cnt_d;
            led4_q     <= led4_d;
            strobe_q   <= strobe_d;
            eval_q     <= eval_d;
            history_q  <= history_d;
            led3_q     <= led3_d;
            fill_q     <= fill_d;
            ser_q      <= ser_d;
            cnt_q      <= cnt_d;
        end
    end

    assign serOut   = ser_q;
    assign synchOut = strobe_q;
    assign matchCnt = cnt_q;
    assign history  = history_q;
    assign LED3     = led3_q;
    assign LED4     = led4_q;

endmodule

// File: tb/tb_seq_detect_frontend.sv
// tb/tb_seq_detect_frontend.sv - randomized bench for seq_detect_frontend against a per-sample reference model
`timescale 1ns/1ps
module tb_seq_detect_frontend;

    localparam int DIV = 10;
    localparam int DEB = 4;
    localparam int NI  = 3;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       pb     = 1'b1;
    logic       sw     = 1'b0;
    logic       auto_m = 1'b0;

    logic       ser    [NI];
    logic       sync_o [NI];
    logic [3:0] hist   [NI];
    logic       led3   [NI];
    logic       led4   [NI];
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic [7:0] cnt_w  [NI];

    assign cnt_w[0] = cnt0;
    assign cnt_w[1] = cnt1;
    assign cnt_w[2] = {6'b0, cnt2};

    always #5 clk = ~clk;

    seq_detect_frontend #(.DIV_COUNT(DIV), .DEBOUNCE_CYC(DEB), .PAT_W(4), .PATTERN(4'b1011),
                          .OVERLAP(1'b1), .CNT_W(8)) u0 (
        .FPGAclk(clk), .startSeq(rst_n), .clkPb(pb), .SwitchIn(sw), .autoMode(auto_m),
        .serOut(ser[0]), .synchOut(sync_o[0]), .matchCnt(cnt0), .history(hist[0]),
        .LED3(led3[0]), .LED4(led4[0]));

    seq_detect_frontend #(.DIV_COUNT(DIV), .DEBOUNCE_CYC(DEB), .PAT_W(4), .PATTERN(4'b1011),
                          .OVERLAP(1'b0), .CNT_W(8)) u1 (
        .FPGAclk(clk), .startSeq(rst_n), .clkPb(pb), .SwitchIn(sw), .autoMode(auto_m),
        .serOut(ser[1]), .synchOut(sync_o[1]), .matchCnt(cnt1), .history(hist[1]),
        .LED3(led3[1]), .LED4(led4[1]));

    seq_detect_frontend #(.DIV_COUNT(DIV), .DEBOUNCE_CYC(DEB), .PAT_W(4), .PATTERN(4'b1111),
                          .OVERLAP(1'b1), .CNT_W(2)) u2 (
        .FPGAclk(clk), .startSeq(rst_n), .clkPb(pb), .SwitchIn(sw), .autoMode(auto_m),
        .serOut(ser[2]), .synchOut(sync_o[2]), .matchCnt(cnt2), .history(hist[2]),
        .LED3(led3[2]), .LED4(led4[2]));

    int n_checks = 0;
    int n_pass   = 0;
    int strobe_cnt = 0;
    int cyc = 0;

    // Reference model: one update per sample, straight from the matching rules.
    int pat  [NI] = '{11, 11, 15};
    int ov   [NI] = '{1, 0, 1};
    int cmax [NI] = '{255, 255, 3};
    int m_hist [NI];
    int m_fill [NI];
    int m_cnt  [NI];
    int m_ser  [NI];
    int m_last;

    always @(posedge clk) begin
        cyc++;
        #2;
        if (sync_o[0] === 1'b1) strobe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_hist[i] = 0; m_fill[i] = 0; m_cnt[i] = 0; m_ser[i] = 0;
        end
        m_last = 0;
    endtask

    task automatic model_sample(input int b);
        m_last = b;
        for (int i = 0; i < NI; i++) begin
            int hit;
            m_hist[i] = ((m_hist[i] << 1) | b) & 15;
            if (m_fill[i] < 4) m_fill[i]++;
            hit = (m_fill[i] == 4 && m_hist[i] == pat[i]) ? 1 : 0;
            m_ser[i] = hit;
            if (hit != 0) begin
                if (m_cnt[i] < cmax[i]) m_cnt[i]++;
                if (ov[i] == 0) m_fill[i] = 0;
            end
        end
    endtask

    task automatic check_outputs(input string ph);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("%s u%0d serOut", ph, i), 32'(ser[i]), m_ser[i]);
            check_eq($sformatf("%s u%0d matchCnt", ph, i), 32'(cnt_w[i]), m_cnt[i]);
            check_eq($sformatf("%s u%0d history", ph, i), 32'(hist[i]), m_hist[i]);
        end
        check_eq($sformatf("%s LED3", ph), 32'(led3[0]), m_last);
    endtask

    task automatic check_all_zero(input string ph);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("%s u%0d serOut", ph, i), 32'(ser[i]), 0);
            check_eq($sformatf("%s u%0d synchOut", ph, i), 32'(sync_o[i]), 0);
            check_eq($sformatf("%s u%0d matchCnt", ph, i), 32'(cnt_w[i]), 0);
            check_eq($sformatf("%s u%0d history", ph, i), 32'(hist[i]), 0);
            check_eq($sformatf("%s u%0d LED3", ph, i), 32'(led3[i]), 0);
            check_eq($sformatf("%s u%0d LED4", ph, i), 32'(led4[i]), 0);
        end
    endtask

    task automatic release_and_time(input string ph);
        int first;
        first = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (led4[0] === 1'b1 && first == 0) first = k;
        end
        check_eq({ph, " LED4 first toggle cycle"}, first, DIV);
        model_reset();
    endtask

    // One button press sampling bit b: checks latency, single strobe, model outputs.
    task automatic do_press(input int b, input string ph);
        int lat;
        int s0;
        @(negedge clk);
        sw = b[0];
        repeat (4) @(negedge clk);
        s0  = strobe_cnt;
        pb  = 1'b0;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (sync_o[0] === 1'b1) begin
                lat = k;
                break;
            end
        end
        check_eq({ph, " press latency"}, lat, 2 + DEB + 1);
        repeat (3) @(negedge clk);
        pb = 1'b1;
        repeat (12) @(negedge clk);
        check_eq({ph, " strobes per press"}, strobe_cnt - s0, 1);
        model_sample(b);
        check_outputs(ph);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dir_seq [7] = '{1, 0, 1, 1, 0, 1, 1};
        int s0;
        int last_cyc;

        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        release_and_time("reset");

        // Short bounces must not be accepted.
        s0 = strobe_cnt;
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            pb = 1'b0;
            repeat (2) @(negedge clk);
            pb = 1'b1;
            repeat (8) @(negedge clk);
        end
        check_eq("bounce no strobe", strobe_cnt - s0, 0);

        for (int i = 0; i < 7; i++) do_press(dir_seq[i], $sformatf("dir%0d", i));
        check_eq("dir u0 matchCnt", 32'(cnt0), 2);
        check_eq("dir u0 history", 32'(hist[0]), 4'b1011);
        check_eq("dir u1 matchCnt", 32'(cnt1), 1);

        for (int i = 0; i < 10; i++) do_press(int'($urandom_range(0, 1)), $sformatf("rnd%0d", i));

        // Auto mode: ticks drive sampling, button presses are ignored.
        @(negedge clk);
        sw = 1'b1;
        repeat (3) @(negedge clk);
        auto_m   = 1'b1;
        last_cyc = 0;
        for (int t = 0; t < 20; t++) begin
            int got;
            got = 0;
            for (int k = 1; k <= 30; k++) begin
                @(negedge clk);
                if (sync_o[0] === 1'b1) begin
                    got = 1;
                    break;
                end
            end
            check_eq($sformatf("auto%0d strobe seen", t), got, 1);
            if (t > 0) check_eq($sformatf("auto%0d spacing", t), cyc - last_cyc, DIV);
            last_cyc = cyc;
            model_sample(int'(sw));
            if (t >= 8) sw = 1'($urandom_range(0, 1));
            if (t < 19) pb = 1'b0;
            repeat (6) @(negedge clk);
            pb = 1'b1;
            check_outputs($sformatf("auto%0d", t));
        end
        auto_m = 1'b0;
        s0 = strobe_cnt;
        repeat (25) @(negedge clk);
        check_eq("mode change no strobe", strobe_cnt - s0, 0);

        // Mid-run reset clears outputs asynchronously, before the next edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        repeat (5) @(negedge clk);
        release_and_time("midreset");

        for (int i = 0; i < 8; i++) do_press(int'($urandom_range(0, 1)), $sformatf("post%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
